// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Control FSM for a multicycle datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH. Every control output
// is decoded from the state register and the latched instruction register
// (IR). The only exceptions are the input terms that the protocol makes
// same-cycle:
//   - the branch decision uses alu_zero in EXEC;
//   - a store retires in the MEM cycle that sees mem_ack.
//
// Optional feature: define MEM_TIMEOUT_EN to bound the MEM wait to
// TIMEOUT_CYC cycles. When it times out, mem_err pulses and the instruction
// retires without a register write. Without the macro, MEM waits
// indefinitely and mem_err is tied to 0.
//
// Handshake (instr_valid / instr_ready): an instruction transfers on a rising
// clk edge where both are 1. instr_ready is a function of registered state
// only, never of instr_valid. instr_ready is 1 only in FETCH, and only once
// reset has been released for at least one edge. instr_valid and instruction
// are ignored whenever instr_ready is 0.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   instr_valid/ready   fetch handshake; instruction latched into IR on transfer
//   instruction         INSTR_W bits, opcode in the top 4 bits
//   mem_ack             memory completion, only observed in MEM
//   alu_zero            ALU result is zero, only observed in EXEC for branches
//   mem_r_en/mem_w_en   memory read/write strobes, held through MEM
//   reg_w_en            register file write, one cycle in WB
//   pc_en, pc_src       PC update and source (0 PC+1, 1 jump, 2 branch)
//   sel_w_source        write-back mux (0 ALU, 1 memory, 2 link)
//   reg_addr_0/1/w      register read/write addresses from IR fields
//   alu_op              opcode forwarded to the ALU
//   busy                1 in every state but FETCH
//   mem_err             MEM timeout pulse (0 unless MEM_TIMEOUT_EN)
//   retired_count       count of retired instructions, wraps at 16 bits
//   state_dbg           current FSM state encoding
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int INSTR_W     = 8,
  parameter int RA_W        = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ack,
  input  logic               alu_zero,
  output logic               mem_r_en,
  output logic               mem_w_en,
  output logic               reg_w_en,
  output logic               pc_en,
  output logic [1:0]         sel_w_source,
  output logic [1:0]         pc_src,
  output logic [RA_W-1:0]    reg_addr_0,
  output logic [RA_W-1:0]    reg_addr_1,
  output logic [RA_W-1:0]    reg_addr_w,
  output logic [3:0]         alu_op,
  output logic               busy,
  output logic               mem_err,
  output logic [15:0]        retired_count,
  output logic [2:0]         state_dbg
);

  if (TIMEOUT_CYC < 1) begin : g_timeout_cyc_invalid
    $error("multicycle_control_unit: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_J   = 4'h8;
  localparam logic [3:0] OP_JAL = 4'h9;
  localparam logic [3:0] OP_LW  = 4'hA;
  localparam logic [3:0] OP_SW  = 4'hB;
  localparam logic [3:0] OP_BEQ = 4'hC;
  localparam logic [3:0] OP_BNE = 4'hD;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  localparam logic [1:0] WSRC_ALU  = 2'd0;
  localparam logic [1:0] WSRC_MEM  = 2'd1;
  localparam logic [1:0] WSRC_LINK = 2'd2;

  state_t             state;
  logic [INSTR_W-1:0] ir;
  // Clear during reset so instr_ready stays low until the first edge after
  // reset is released, even though the state is already FETCH.
  logic               active;

  logic [3:0]      opcode;
  logic [RA_W-1:0] fld_a;
  logic [RA_W-1:0] fld_b;
  logic            is_j, is_jal, is_lw, is_sw, is_beq, is_bne;
  logic            branch_taken;

  assign opcode = ir[INSTR_W-1 -: 4];
  assign fld_a  = ir[RA_W-1:0];
  assign fld_b  = ir[2*RA_W-1:RA_W];

  assign is_j   = (opcode == OP_J);
  assign is_jal = (opcode == OP_JAL);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);
  assign is_bne = (opcode == OP_BNE);

  assign branch_taken = (is_beq & alu_zero) | (is_bne & ~alu_zero);

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // wait_cnt holds the number of MEM cycles already spent without mem_ack.
  // The timeout therefore fires in MEM cycle TIMEOUT_CYC.
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;
  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
`endif

  // Decode fields straight from IR. They are valid from DECODE until the
  // instruction retires, because IR only reloads on the next handshake.
  assign reg_addr_0 = fld_a;
  assign reg_addr_1 = fld_b;
  assign alu_op     = opcode;
  assign state_dbg  = state;

  always_comb begin
    sel_w_source = WSRC_ALU;
    if (is_lw)       sel_w_source = WSRC_MEM;
    else if (is_jal) sel_w_source = WSRC_LINK;
  end

  always_comb begin
    case (opcode)
      4'h1, 4'h2, 4'h4, 4'h5: reg_addr_w = '0;
      OP_JAL:                 reg_addr_w = '1;
      default:                reg_addr_w = fld_b;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    mem_r_en    = 1'b0;
    mem_w_en    = 1'b0;
    reg_w_en    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PC_INC;
    mem_err     = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = active;
      end
      S_DECODE: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (is_j) begin
          pc_en  = 1'b1;
          pc_src = PC_JUMP;
        end else if (is_beq || is_bne) begin
          pc_en  = 1'b1;
          pc_src = branch_taken ? PC_BRANCH : PC_INC;
        end
      end
      S_MEM: begin
        busy     = 1'b1;
        mem_r_en = is_lw;
        mem_w_en = is_sw;
        // A store finishes in the ack cycle itself; a load retires in WB.
        if (mem_ack && is_sw) pc_en = 1'b1;
`ifdef MEM_TIMEOUT_EN
        // An ack in the final window cycle still wins over the timeout.
        if (!mem_ack && timeout_hit) begin
          mem_err = 1'b1;
          pc_en   = 1'b1;
        end
`endif
      end
      S_WB: begin
        busy     = 1'b1;
        reg_w_en = 1'b1;
        pc_en    = 1'b1;
        pc_src   = is_jal ? PC_JUMP : PC_INC;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      ir            <= '0;
      retired_count <= '0;
      active        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      active <= 1'b1;
      if (pc_en) retired_count <= retired_count + 16'd1;
      case (state)
        S_FETCH: begin
          if (instr_valid && instr_ready) begin
            ir    <= instruction;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_j || is_beq || is_bne) begin
            state <= S_FETCH;
          end else if (is_lw || is_sw) begin
            state <= S_MEM;
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            // ALU ops, li/addi and jal all write back.
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            state <= is_lw ? S_WB : S_FETCH;
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_WB: begin
          state <= S_FETCH;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
